// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator: buffers two prior rows of a raster pixel stream and
// emits one window per interior position over a valid/ready handshake.
module window_3x3_gen #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [15:0]                pixel_in,
  output logic                       in_ready,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [9*PIX_W-1:0]         win_out,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int HIST  = 2 * IMG_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // hist[k-1] holds the pixel accepted k pixels ago: one row back is hist[IMG_W-1],
  // two rows back is hist[2*IMG_W-1], both at the same column as the incoming pixel.
  logic [PIX_W-1:0] hist [HIST];
  logic [PIX_W-1:0] win  [9];
  logic [RW-1:0]    row_cnt;
  logic [CW-1:0]    col_cnt;

  logic             accept;
  logic             produce;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] pix;
  logic             unused_pix_hi;

  assign pix           = pixel_in[PIX_W-1:0];
  assign unused_pix_hi = ^{1'b0, pixel_in};

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (col_cnt == COL_LAST);
  assign last_row = (row_cnt == ROW_LAST);
  assign produce  = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

  always_comb begin
    win_out = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      win_out[k*PIX_W +: PIX_W] = win[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < HIST; i++) begin
        hist[i] <= '0;
      end
      for (int unsigned k = 0; k < 9; k++) begin
        win[k] <= '0;
      end
      row_cnt    <= '0;
      col_cnt    <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        hist[0] <= pix;
        for (int unsigned i = 1; i < HIST; i++) begin
          hist[i] <= hist[i-1];
        end
        for (int unsigned r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= hist[HIST-1];
        win[5] <= hist[IMG_W-1];
        win[8] <= pix;

        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end

      // A producing accept overwrites any window being taken this cycle, so there is no bubble.
      if (accept && produce) begin
        win_valid  <= 1'b1;
        win_row    <= row_cnt;
        win_col    <= col_cnt;
        frame_done <= last_row && last_col;
      end else if (win_ready) begin
        win_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen (4x4 image, 8-bit pixels): expected windows are
// computed from the frame pixels and matched in order against every output handshake.
module tb_window_3x3_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] pixel_in;
  logic        in_ready;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_out;
  logic [1:0]  win_row;
  logic [1:0]  win_col;
  logic        frame_done;

  logic dir_ready = 1'b1;
  logic rnd_ready = 1'b1;
  logic rand_mode = 1'b0;
  assign win_ready = rand_mode ? rnd_ready : dir_ready;

  window_3x3_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_in(pixel_in), .in_ready(in_ready),
    .win_valid(win_valid), .win_ready(win_ready), .win_out(win_out), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] w;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        fd;
  } exp_t;

  exp_t        q[$];
  logic [15:0] frm [16];
  int          checks = 0;
  int          failures = 0;
  int          consumed = 0;
  logic [71:0] w_first;
  logic [71:0] w_last;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference windows straight from the frame image.
  task automatic queue_frame();
    exp_t e;
    for (int r = 2; r < 4; r++) begin
      for (int c = 2; c < 4; c++) begin
        e.w = '0;
        for (int k = 0; k < 9; k++) begin
          e.w[k*8 +: 8] = frm[(r - 2 + k / 3) * 4 + (c - 2 + k % 3)][7:0];
        end
        e.r  = 2'(r);
        e.c  = 2'(c);
        e.fd = (r == 3) && (c == 3);
        q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [15:0] p);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    pixel_in = p;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic send_frame(input logic stall, input logic gaps);
    queue_frame();
    for (int i = 0; i < 16; i++) begin
      send(frm[i]);
      // After an accept, win_valid reflects exactly whether that pixel produced a window.
      chk("latency_valid", win_valid, (i / 4 >= 2) && (i % 4 >= 2));
      chk("frame_done_pos", frame_done, i == 15);
      if (i == 10) w_first = win_out;
      if (i == 15) w_last = win_out;
      if (stall && i == 10) begin
        dir_ready = 1'b0;
        in_valid  = 1'b1;
        pixel_in  = frm[11];
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          #1;
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_hold_win", win_out, w_first);
          chk("stall_hold_valid", win_valid, 1'b1);
        end
        dir_ready = 1'b1;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, "_valid"}, win_valid, 1'b0);
    chk({tag, "_win"}, win_out, '0);
    chk({tag, "_row"}, win_row, 2'd0);
    chk({tag, "_col"}, win_col, 2'd0);
    chk({tag, "_fd"}, frame_done, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && win_valid === 1'b1) begin
      chk("in_ready_when_valid", in_ready, win_ready);
      if (win_ready) begin
        if (q.size() == 0) begin
          chk("extra_window", 72'(q.size()), 72'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("win_out", win_out, e.w);
          chk("win_row", win_row, e.r);
          chk("win_col", win_col, e.c);
          chk("frame_done", frame_done, e.fd);
          consumed++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0;
    pixel_in = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_and_check("reset_init");

    // Test 1: pixels 1..16, win_ready held high.
    for (int i = 0; i < 16; i++) frm[i] = 16'(i + 1);
    send_frame(1'b0, 1'b0);
    chk("t1_first_window", w_first, {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
    chk("t1_last_window", w_last, {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6});

    // Test 2: same stream, downstream stalls 3 cycles after the first window.
    send_frame(1'b1, 1'b0);

    // Test 3: upper pixel bits are ignored.
    for (int i = 0; i < 16; i++) frm[i] = {8'hC3, 8'(i + 20)};
    frm[15] = 16'hAB05;
    send_frame(1'b0, 1'b0);
    chk("t3_hi_bits_ignored", w_last[71:64], 8'h05);

    // Test 4: two frames back to back.
    for (int i = 0; i < 16; i++) frm[i] = 16'(i + 1);
    send_frame(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) frm[i] = 16'(i + 101);
    send_frame(1'b0, 1'b0);
    chk("t4_f2_first_window", w_first,
        {8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105, 8'd103, 8'd102, 8'd101});

    // Test 5: reset after a partial frame, then a clean frame.
    for (int i = 0; i < 7; i++) send(16'(i + 50));
    reset_and_check("reset_mid");
    for (int i = 0; i < 16; i++) frm[i] = 16'(i + 1);
    send_frame(1'b0, 1'b0);
    chk("t5_first_window", w_first, {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});

    // Test 6: random input gaps and downstream backpressure over 3 frames.
    rand_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) frm[i] = 16'($urandom_range(0, 65535));
      send_frame(1'b0, 1'b1);
    end
    @(negedge clk);
    rand_mode = 1'b0;
    dir_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_queue_empty", 72'(q.size()), 72'd0);
    chk("drain_valid_low", win_valid, 1'b0);
    chk("window_count", 72'(consumed), 72'd36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
